// File: rtl/game_sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_sprite_pkg
// Description : Shared types, default dimensions and velocity helpers for the
//               sprite driver.
// Revision    : 1.0 - initial release
// ============================================================================
package game_sprite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_XY  = 3'd1,
    ST_LOAD_DXY = 3'd2,
    ST_RUN      = 3'd3,
    ST_BOUNCE   = 3'd4
  } state_t;

  localparam int C_SCREEN_W = 640;
  localparam int C_SCREEN_H = 480;
  localparam int C_SPRITE_W = 8;
  localparam int C_SPRITE_H = 8;

  // Negate a w-bit two's complement value (sign-extended to 32 bits).
  // The most negative value has no positive counterpart, so it clamps to
  // the largest positive value instead of wrapping back to itself.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v,
                                                 input int w);
    logic signed [31:0] lo;
    logic signed [31:0] hi;
    lo = -(32'sd1 <<< (w - 1));
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (v <= lo) return hi;
    return -v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_sprite_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : game_sprite_edge_detect
// Description : Combinational screen-edge hit test for one axis. A hit means
//               the next step at the current velocity would leave the screen.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sprite_edge_detect
  import game_sprite_pkg::*;
#(
  parameter int POS_WIDTH = 10,
  parameter int D_WIDTH   = 2,
  parameter int SCREEN    = 640,
  parameter int SPRITE    = 8
) (
  input  logic [POS_WIDTH-1:0] i_pos,
  input  logic [D_WIDTH-1:0]   i_d,
  output logic                 o_hit
);

  // One extra bit of headroom so position + size + step can never wrap.
  localparam logic [POS_WIDTH:0] c_sprite = (POS_WIDTH + 1)'(SPRITE);
  localparam logic [POS_WIDTH:0] c_screen = (POS_WIDTH + 1)'(SCREEN);

  logic               w_neg;
  logic               w_zero;
  logic [POS_WIDTH:0] w_pos;
  logic [POS_WIDTH:0] w_d_ext;
  logic [POS_WIDTH:0] w_mag;
  logic [POS_WIDTH:0] w_far;

  assign w_neg   = i_d[D_WIDTH-1];
  assign w_zero  = (i_d == '0);
  assign w_pos   = {1'b0, i_pos};
  assign w_d_ext = {{(POS_WIDTH + 1 - D_WIDTH){i_d[D_WIDTH-1]}}, i_d};
  assign w_mag   = -w_d_ext;
  assign w_far   = w_pos + c_sprite + w_d_ext;

  // Low edge only matters when moving backwards, high edge only when moving forwards.
  assign o_hit = (w_neg && (w_pos < w_mag)) ||
                 (!w_neg && !w_zero && (w_far > c_screen));

endmodule
`default_nettype wire

// File: rtl/game_sprite_driver.sv
`default_nettype none
// ============================================================================
// Module      : game_sprite_driver
// Description : Loads start position/velocity into the sprite controller,
//               enables motion and reverses velocity on screen-edge hits.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sprite_driver
  import game_sprite_pkg::*;
#(
  parameter int X_WIDTH  = 10,
  parameter int Y_WIDTH  = 10,
  parameter int DX_WIDTH = 2,
  parameter int DY_WIDTH = 2,
  parameter int SCREEN_W = C_SCREEN_W,
  parameter int SCREEN_H = C_SCREEN_H,
  parameter int SPRITE_W = C_SPRITE_W,
  parameter int SPRITE_H = C_SPRITE_H
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [X_WIDTH-1:0]  i_start_x,
  input  logic [Y_WIDTH-1:0]  i_start_y,
  input  logic [DX_WIDTH-1:0] i_start_dx,
  input  logic [DY_WIDTH-1:0] i_start_dy,
  input  logic [X_WIDTH-1:0]  i_sprite_x,
  input  logic [Y_WIDTH-1:0]  i_sprite_y,
  output logic                o_sprite_write_xy,
  output logic                o_sprite_write_dxy,
  output logic [X_WIDTH-1:0]  o_sprite_write_x,
  output logic [Y_WIDTH-1:0]  o_sprite_write_y,
  output logic [DX_WIDTH-1:0] o_sprite_write_dx,
  output logic [DY_WIDTH-1:0] o_sprite_write_dy,
  output logic                o_sprite_enable_update,
  output logic                o_running,
  output logic                o_bounce
);

  state_t              r_state;
  logic [DX_WIDTH-1:0] r_dx;
  logic [DY_WIDTH-1:0] r_dy;
  logic                r_write_xy;
  logic                r_write_dxy;
  logic [X_WIDTH-1:0]  r_write_x;
  logic [Y_WIDTH-1:0]  r_write_y;
  logic [DX_WIDTH-1:0] r_write_dx;
  logic [DY_WIDTH-1:0] r_write_dy;
  logic                r_enable;
  logic                r_running;
  logic                r_bounce;

  logic                w_hit_x;
  logic                w_hit_y;
  logic [DX_WIDTH-1:0] w_dx_neg;
  logic [DY_WIDTH-1:0] w_dy_neg;
  logic [DX_WIDTH-1:0] w_next_dx;
  logic [DY_WIDTH-1:0] w_next_dy;

  game_sprite_edge_detect #(
    .POS_WIDTH (X_WIDTH),
    .D_WIDTH   (DX_WIDTH),
    .SCREEN    (SCREEN_W),
    .SPRITE    (SPRITE_W)
  ) u_edge_x (
    .i_pos (i_sprite_x),
    .i_d   (r_dx),
    .o_hit (w_hit_x)
  );

  game_sprite_edge_detect #(
    .POS_WIDTH (Y_WIDTH),
    .D_WIDTH   (DY_WIDTH),
    .SCREEN    (SCREEN_H),
    .SPRITE    (SPRITE_H)
  ) u_edge_y (
    .i_pos (i_sprite_y),
    .i_d   (r_dy),
    .o_hit (w_hit_y)
  );

  assign w_dx_neg  = DX_WIDTH'(sat_neg({{(32 - DX_WIDTH){r_dx[DX_WIDTH-1]}}, r_dx}, DX_WIDTH));
  assign w_dy_neg  = DY_WIDTH'(sat_neg({{(32 - DY_WIDTH){r_dy[DY_WIDTH-1]}}, r_dy}, DY_WIDTH));
  assign w_next_dx = w_hit_x ? w_dx_neg : r_dx;
  assign w_next_dy = w_hit_y ? w_dy_neg : r_dy;

  // Control FSM; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dx        <= '0;
      r_dy        <= '0;
      r_write_xy  <= 1'b0;
      r_write_dxy <= 1'b0;
      r_write_x   <= '0;
      r_write_y   <= '0;
      r_write_dx  <= '0;
      r_write_dy  <= '0;
      r_enable    <= 1'b0;
      r_running   <= 1'b0;
      r_bounce    <= 1'b0;
    end else begin
      r_write_xy  <= 1'b0;
      r_write_dxy <= 1'b0;
      r_bounce    <= 1'b0;
      if (i_stop) begin
        r_state   <= ST_IDLE;
        r_enable  <= 1'b0;
        r_running <= 1'b0;
      end else if (i_start) begin
        r_state    <= ST_LOAD_XY;
        r_dx       <= i_start_dx;
        r_dy       <= i_start_dy;
        r_write_xy <= 1'b1;
        r_write_x  <= i_start_x;
        r_write_y  <= i_start_y;
        r_enable   <= 1'b0;
        r_running  <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD_XY: begin
            r_state     <= ST_LOAD_DXY;
            r_write_dxy <= 1'b1;
            r_write_dx  <= r_dx;
            r_write_dy  <= r_dy;
          end
          ST_LOAD_DXY: begin
            r_state   <= ST_RUN;
            r_enable  <= 1'b1;
            r_running <= 1'b1;
          end
          ST_RUN: begin
            if (w_hit_x || w_hit_y) begin
              r_state     <= ST_BOUNCE;
              r_enable    <= 1'b0;
              r_write_dxy <= 1'b1;
              r_bounce    <= 1'b1;
              r_write_dx  <= w_next_dx;
              r_write_dy  <= w_next_dy;
              r_dx        <= w_next_dx;
              r_dy        <= w_next_dy;
            end
          end
          ST_BOUNCE: begin
            r_state  <= ST_RUN;
            r_enable <= 1'b1;
          end
          default: begin
            r_state   <= ST_IDLE;
            r_enable  <= 1'b0;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sprite_write_xy      = r_write_xy;
  assign o_sprite_write_dxy     = r_write_dxy;
  assign o_sprite_write_x       = r_write_x;
  assign o_sprite_write_y       = r_write_y;
  assign o_sprite_write_dx      = r_write_dx;
  assign o_sprite_write_dy      = r_write_dy;
  assign o_sprite_enable_update = r_enable;
  assign o_running              = r_running;
  assign o_bounce               = r_bounce;

endmodule
`default_nettype wire
